digit_scan_mux: RTL and testbench



---
 rtl/digit_scan_mux.sv | 101 ++++++++++
 tb/tb_digit_scan_mux.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_mux.sv
// Purpose : time-multiplexed seven-segment digit scanner with a double-buffered display word.
// Latency : outputs decode combinationally from registered state; a load shows up at the next frame wrap.
// Backpress: none; load is always accepted, and a later load overwrites an uncommitted one.
module digit_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int DIV           = 50000,
    parameter bit AN_ACTIVE_LOW = 1'b1,
    localparam int IW           = $clog2(NUM_DIGITS),
    localparam int PW           = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic                    pending,
    output logic                    w,
    output logic                    x,
    output logic                    y,
    output logic                    z,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_tick
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PS  = PW'(DIV - 1);

    // One display word: nibbles plus per-digit blank mask
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   blank;
    } disp_t;

    logic [PW-1:0] prescaler;
    logic          step;
    logic          wrap;
    disp_t         shadow;
    disp_t         active;
    logic [3:0]    nibble;
    logic [NUM_DIGITS-1:0] an_act;

    assign step = (prescaler == LAST_PS);
    assign wrap = step && (digit_idx == LAST_IDX);

    // Dwell counter: one step every DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (step) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Digit sequencer and first-cycle-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (step) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Double buffer: commit takes the pre-edge shadow, so a load on the wrap edge waits a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '{value: '0, blank: '1};
            pending <= 1'b0;
        end else begin
            if (wrap && pending) begin
                active <= shadow;
            end
            if (load) begin
                shadow  <= '{value: value_in, blank: blank_in};
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Nibble select and one-hot digit enable; nibble is driven even for blanked digits
    always_comb begin
        nibble = active.value[4*digit_idx +: 4];
        an_act = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_act[k] = (digit_idx == IW'(k)) && !active.blank[k];
        end
    end

    assign {w, x, y, z} = nibble;
    assign an = AN_ACTIVE_LOW ? ~an_act : an_act;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Purpose : directed checks of digit_scan_mux with NUM_DIGITS=4, DIV=4, active-low enables.
// Latency : edge n counts rising edges after rst drops (edge 0 first); values sampled 1ns after the edge.
// Backpress: not applicable.
module tb_digit_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        pending;
    logic        w, x, y, z;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int n_assert = 0;
    int n_fail   = 0;
    int e        = -1;

    digit_scan_mux #(
        .NUM_DIGITS    (4),
        .DIV           (4),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .blank_in   (blank_in),
        .load       (load),
        .pending    (pending),
        .w          (w),
        .x          (x),
        .y          (y),
        .z          (z),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until edge n has occurred, then settle 1ns past it
    task automatic go_to(input int n);
        while (e < n) begin
            @(posedge clk);
            e++;
            #1;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e   = -1;
    endtask

    // Present a load so that it is sampled on edge n
    task automatic load_at(input int n, input logic [15:0] v, input logic [3:0] b);
        go_to(n - 1);
        value_in = v;
        blank_in = b;
        load     = 1'b1;
        go_to(n);
        load     = 1'b0;
        value_in = 16'hDEAD;
        blank_in = 4'hF;
    endtask

    task automatic chk_disp(input string tag, input logic [1:0] idx, input logic [3:0] nib,
                            input logic [3:0] an_exp);
        chk({tag, "_idx"},  32'(digit_idx),      32'(idx));
        chk({tag, "_wxyz"}, 32'({w, x, y, z}),   32'(nib));
        chk({tag, "_an"},   32'(an),             32'(an_exp));
    endtask

    initial begin
        value_in = 16'h0;
        blank_in = 4'h0;
        load     = 1'b0;
        rst      = 1'b1;

        // Reset state and free-running scan with no load
        do_reset();
        chk_disp("rst", 2'd0, 4'h0, 4'b1111);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        go_to(2);  chk("t1_idx_e2", 32'(digit_idx), 32'd0);
        go_to(3);  chk("t1_idx_e3", 32'(digit_idx), 32'd1);
        go_to(11); chk_disp("t1_e11", 2'd3, 4'h0, 4'b1111);
        go_to(14); chk("t1_tick_e14", 32'(frame_tick), 32'd0);
        go_to(15); chk("t1_tick_e15", 32'(frame_tick), 32'd1);
        chk("t1_idx_e15", 32'(digit_idx), 32'd0);
        go_to(16); chk("t1_tick_e16", 32'(frame_tick), 32'd0);
        go_to(31); chk("t1_tick_e31", 32'(frame_tick), 32'd1);
        chk("t1_pending", 32'(pending), 32'd0);

        // Single load commits at the first wrap
        do_reset();
        load_at(1, 16'h1234, 4'b0000);
        chk("t2_pend_e1", 32'(pending), 32'd1);
        go_to(14); chk("t2_pend_e14", 32'(pending), 32'd1);
        chk_disp("t2_e14", 2'd3, 4'h0, 4'b1111);
        go_to(15); chk("t2_pend_e15", 32'(pending), 32'd0);
        chk_disp("t2_d0", 2'd0, 4'h4, 4'b1110);
        go_to(19); chk_disp("t2_d1", 2'd1, 4'h3, 4'b1101);
        go_to(23); chk_disp("t2_d2", 2'd2, 4'h2, 4'b1011);
        go_to(27); chk_disp("t2_d3", 2'd3, 4'h1, 4'b0111);

        // Blanked digit keeps its nibble but has no enable
        do_reset();
        load_at(1, 16'hA5F0, 4'b0100);
        go_to(15); chk_disp("t3_d0", 2'd0, 4'h0, 4'b1110);
        go_to(19); chk_disp("t3_d1", 2'd1, 4'hF, 4'b1101);
        go_to(23); chk_disp("t3_d2", 2'd2, 4'h5, 4'b1111);
        go_to(27); chk_disp("t3_d3", 2'd3, 4'hA, 4'b0111);

        // Two loads before commit: last one wins
        do_reset();
        load_at(3, 16'h1111, 4'b0000);
        load_at(5, 16'h2222, 4'b0000);
        go_to(14); chk("t4_wxyz_e14", 32'({w, x, y, z}), 32'h0);
        go_to(15); chk_disp("t4_d0", 2'd0, 4'h2, 4'b1110);
        chk("t4_pend", 32'(pending), 32'd0);
        go_to(19); chk_disp("t4_d1", 2'd1, 4'h2, 4'b1101);

        // Load on the wrap edge: old shadow commits, new data waits a frame
        do_reset();
        load_at(3, 16'hAAAA, 4'b0000);
        load_at(15, 16'hBBBB, 4'b0000);
        chk_disp("t5_e15", 2'd0, 4'hA, 4'b1110);
        chk("t5_pend_e15", 32'(pending), 32'd1);
        chk("t5_tick_e15", 32'(frame_tick), 32'd1);
        go_to(30); chk_disp("t5_e30", 2'd3, 4'hA, 4'b0111);
        chk("t5_pend_e30", 32'(pending), 32'd1);
        go_to(31); chk_disp("t5_e31", 2'd0, 4'hB, 4'b1110);
        chk("t5_pend_e31", 32'(pending), 32'd0);

        // Load with nothing pending on a wrap edge commits one frame later
        do_reset();
        load_at(15, 16'h4321, 4'b0000);
        chk("t7_pend_e15", 32'(pending), 32'd1);
        chk_disp("t7_e15", 2'd0, 4'h0, 4'b1111);
        go_to(31); chk_disp("t7_e31", 2'd0, 4'h1, 4'b1110);
        chk("t7_pend_e31", 32'(pending), 32'd0);

        // Mid-operation reset discards an uncommitted load
        do_reset();
        load_at(3, 16'h1234, 4'b0000);
        go_to(9); chk("t6_pend_e9", 32'(pending), 32'd1);
        chk("t6_idx_e9", 32'(digit_idx), 32'd2);
        rst = 1'b1;
        go_to(10);
        chk_disp("t6_rst", 2'd0, 4'h0, 4'b1111);
        chk("t6_pend_rst", 32'(pending), 32'd0);
        rst = 1'b0;
        e   = -1;
        go_to(2);  chk("t6_idx_e2", 32'(digit_idx), 32'd0);
        go_to(3);  chk("t6_idx_e3", 32'(digit_idx), 32'd1);
        go_to(15); chk("t6_tick_e15", 32'(frame_tick), 32'd1);
        chk_disp("t6_e15", 2'd0, 4'h0, 4'b1111);
        chk("t6_pend_e15", 32'(pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
